// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for a multicycle MIPS datapath. Accepts one
//   single-word read or write request at a time. The request is held for
//   WAIT_CYCLES wait states, then the internal word-addressed RAM is
//   accessed. Completion is signalled by a one-cycle ready pulse, and any
//   addressing error is reported alongside that pulse.
//
// Handshake:
//   A request is accepted when mem_req=1 at a rising edge while the unit is
//   idle (mem_busy=0). mem_we, mem_addr and mem_wdata are captured on that
//   same edge. mem_busy rises on the accept edge and stays high until the
//   unit returns to idle. Requests raised while mem_busy=1 are dropped, not
//   queued, so a requester must hold mem_req until it sees mem_busy=1.
//   mem_rdata and mem_err are meaningful only while mem_ready=1.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst        synchronous active-high reset
//   mem_req    request strobe, sampled only when idle
//   mem_we     1 = write, 0 = read
//   mem_addr   byte address (must be word aligned and inside the RAM)
//   mem_wdata  write data
//   mem_rdata  read data, registered
//   mem_ready  one-cycle completion pulse
//   mem_busy   high from the accept edge until the unit is idle again
//   mem_err    misaligned or out-of-range access, valid with mem_ready
module mem_responder #(
  parameter int N           = 32,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_req,
  input  logic         mem_we,
  input  logic [N-1:0] mem_addr,
  input  logic [N-1:0] mem_wdata,
  output logic [N-1:0] mem_rdata,
  output logic         mem_ready,
  output logic         mem_busy,
  output logic         mem_err
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  wait_cnt;
  logic        lat_we;
  logic [N-1:0] lat_addr;
  logic [N-1:0] lat_wdata;

  logic [N-1:0] ram [DEPTH];

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  addr_err;
  logic                  access;

  assign word_idx = lat_addr[DEPTH_LOG2+1:2];
  // Upper bits are checked rather than wrapped onto the RAM.
  assign addr_err = (lat_addr[1:0] != 2'b00) ||
                    ((lat_addr >> (DEPTH_LOG2 + 2)) != '0);
  // The access edge: last edge spent in WAIT.
  assign access   = (state == S_WAIT) && (wait_cnt == 4'd0);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (mem_req) next_state = S_WAIT;
      S_WAIT:  if (wait_cnt == 4'd0) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      mem_ready <= 1'b0;
      mem_busy  <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: begin
          if (mem_req) begin
            lat_we    <= mem_we;
            lat_addr  <= mem_addr;
            lat_wdata <= mem_wdata;
            wait_cnt  <= WAIT_INIT;
            mem_busy  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            mem_ready <= 1'b1;
            mem_err   <= addr_err;
            // Writes and errors both leave zero on the read bus.
            if (addr_err || lat_we) mem_rdata <= '0;
            else                    mem_rdata <= ram[word_idx];
          end
        end
        S_DONE: begin
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          mem_busy  <= 1'b0;
        end
        default: begin
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          mem_busy  <= 1'b0;
        end
      endcase
    end
  end

  // RAM contents survive reset; a write only lands on a non-reset access edge.
  always_ff @(posedge clk) begin
    if (!rst && access && lat_we && !addr_err) begin
      ram[word_idx] <= lat_wdata;
    end
  end

endmodule
